// File: rtl/contador_hacia_arriba_en_ud_lc_counter.sv
// Up/down counter with enable and synchronous parallel load.
// Update priority on each rising edge: reset, then load, then count.
module contador_hacia_arriba_en_ud_lc_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             UD,
    input  logic             LC,
    input  logic [WIDTH-1:0] entradaParalela,
    output logic [WIDTH-1:0] cuenta
);

    logic [WIDTH-1:0] cuenta_q;
    logic [WIDTH-1:0] cuenta_d;
    logic [WIDTH-1:0] paso;

    // Adding all-ones is a decrement modulo 2^WIDTH, so one adder serves both directions.
    assign paso = UD ? {WIDTH{1'b1}} : {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        cuenta_d = cuenta_q;
        if (LC) begin
            cuenta_d = entradaParalela;
        end else if (enable) begin
            cuenta_d = cuenta_q + paso;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta = cuenta_q;

endmodule

// File: tb/tb_contador_hacia_arriba_en_ud_lc_counter.sv
// Randomized and directed bench for the up/down load counter.
// Expected values come from an integer model of the update rules.
module tb_contador_hacia_arriba_en_ud_lc_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         UD;
    logic         LC;
    logic [W-1:0] entradaParalela;
    logic [W-1:0] cuenta;

    int checks = 0;
    int errors = 0;
    int model  = 0;

    contador_hacia_arriba_en_ud_lc_counter #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .UD              (UD),
        .LC              (LC),
        .entradaParalela (entradaParalela),
        .cuenta          (cuenta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input int exp);
        logic [W-1:0] e;
        e = W'(exp);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, e);
        end
    endtask

    // Advance the model with the inputs as they stand, clock, then compare.
    task automatic step(input string tag, input int want);
        if (rst)
            model = 0;
        else if (LC)
            model = int'(entradaParalela);
        else if (enable)
            model = UD ? (model - 1 + MOD) % MOD : (model + 1) % MOD;
        @(posedge clk);
        #1;
        if (want >= 0) chk(tag, cuenta, want);
        else           chk(tag, cuenta, model);
    endtask

    task automatic drive(input logic r, input logic l, input logic e,
                         input logic u, input int p);
        rst = r; LC = l; enable = e; UD = u;
        entradaParalela = W'(p);
    endtask

    initial begin
        drive(1, 1, 0, 0, 7);
        @(negedge clk);

        step("reset", 0);

        drive(0, 1, 1, 0, 5);
        for (int i = 0; i < 10; i++) step("load_hold", 5);
        LC = 0;
        for (int i = 0; i < 12; i++) step("up_wrap", (6 + i) % 16);

        drive(0, 1, 1, 1, 2);
        step("load2", 2);
        LC = 0;
        step("down1", 1);
        step("down0", 0);
        step("down_wrap", 15);
        step("down14", 14);

        drive(0, 1, 0, 0, 9);
        step("load9", 9);
        LC = 0;
        for (int i = 0; i < 5; i++) step("en_hold", 9);
        enable = 1;
        step("en_resume", 10);

        drive(0, 1, 0, 0, 3);
        step("load3", 3);
        drive(1, 1, 0, 0, 12);
        step("prio_rst", 0);
        rst = 0;
        step("prio_load", 12);

        drive(0, 1, 0, 0, 4);
        step("load4", 4);
        drive(0, 0, 1, 0, 0);
        for (int i = 5; i <= 8; i++) step("count_to8", i);
        rst = 1;
        step("mid_rst", 0);
        rst = 0;
        step("post_rst", 1);

        drive(0, 0, 0, 0, 0);
        #2 rst = 1;
        #2 rst = 0;
        step("rst_glitch", 1);

        enable = 1;
        UD = 1;
        #1 chk("no_comb", cuenta, model);
        step("down_after", 0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0,
                  $urandom_range(0, 7) == 0,
                  1'($urandom), 1'($urandom),
                  int'($urandom_range(0, MOD - 1)));
            step("random", -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
